// File: rtl/axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axi_read_arbiter
// Brief    : Two-master to one-slave AXI read arbiter. Round-robin grant on
//            the AR channel, whole-burst ownership of the R channel, sticky
//            burst-length protocol error flag.
// Revision : 1.0 - initial release
// ============================================================================
module axi_read_arbiter (
    input  logic        clk,
    input  logic        rst,

    // Master 0 read address / data
    input  logic [3:0]  ARID_M0,
    input  logic [31:0] ARADDR_M0,
    input  logic [3:0]  ARLEN_M0,
    input  logic [2:0]  ARSIZE_M0,
    input  logic [1:0]  ARBURST_M0,
    input  logic        ARVALID_M0,
    output logic        ARREADY_M0,
    output logic [3:0]  RID_M0,
    output logic [31:0] RDATA_M0,
    output logic [1:0]  RRESP_M0,
    output logic        RLAST_M0,
    output logic        RVALID_M0,
    input  logic        RREADY_M0,

    // Master 1 read address / data
    input  logic [3:0]  ARID_M1,
    input  logic [31:0] ARADDR_M1,
    input  logic [3:0]  ARLEN_M1,
    input  logic [2:0]  ARSIZE_M1,
    input  logic [1:0]  ARBURST_M1,
    input  logic        ARVALID_M1,
    output logic        ARREADY_M1,
    output logic [3:0]  RID_M1,
    output logic [31:0] RDATA_M1,
    output logic [1:0]  RRESP_M1,
    output logic        RLAST_M1,
    output logic        RVALID_M1,
    input  logic        RREADY_M1,

    // DRAM slave port
    output logic [7:0]  ARID_S,
    output logic [31:0] ARADDR_S,
    output logic [3:0]  ARLEN_S,
    output logic [2:0]  ARSIZE_S,
    output logic [1:0]  ARBURST_S,
    output logic        ARVALID_S,
    input  logic        ARREADY_S,
    input  logic [7:0]  RID_S,
    input  logic [31:0] RDATA_S,
    input  logic [1:0]  RRESP_S,
    input  logic        RLAST_S,
    input  logic        RVALID_S,
    output logic        RREADY_S,

    // Status
    output logic        grant,
    output logic        prot_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t      state_q;
    logic        gnt;
    logic        ptr;
    logic [3:0]  cnt;
    logic [3:0]  len_q;
    logic        prot_err_q;

    logic        w_ar_hs;
    logic        w_r_hs;
    logic        w_unused_rid_tag;

    // The upper RID_S nibble is the master tag we inserted; routing is by gnt,
    // so the tag is not needed on the return path.
    assign w_unused_rid_tag = ^RID_S[7:4];

    // AR payload is muxed by the owner; tag the ID with the master number
    assign ARID_S    = gnt ? {4'd1, ARID_M1} : {4'd0, ARID_M0};
    assign ARADDR_S  = gnt ? ARADDR_M1  : ARADDR_M0;
    assign ARLEN_S   = gnt ? ARLEN_M1   : ARLEN_M0;
    assign ARSIZE_S  = gnt ? ARSIZE_M1  : ARSIZE_M0;
    assign ARBURST_S = gnt ? ARBURST_M1 : ARBURST_M0;

    // R payload is broadcast; only the VALID is steered to the owner
    assign RID_M0   = RID_S[3:0];
    assign RID_M1   = RID_S[3:0];
    assign RDATA_M0 = RDATA_S;
    assign RDATA_M1 = RDATA_S;
    assign RRESP_M0 = RRESP_S;
    assign RRESP_M1 = RRESP_S;
    assign RLAST_M0 = RLAST_S;
    assign RLAST_M1 = RLAST_S;

    assign grant    = gnt;
    assign prot_err = prot_err_q;

    assign w_ar_hs = (state_q == ADDR) && ARVALID_S && ARREADY_S;
    assign w_r_hs  = (state_q == DATA) && RVALID_S && RREADY_S;

    // Handshake steering: each channel is only open in its own phase
    always_comb begin
        ARREADY_M0 = 1'b0;
        ARREADY_M1 = 1'b0;
        ARVALID_S  = 1'b0;
        RVALID_M0  = 1'b0;
        RVALID_M1  = 1'b0;
        RREADY_S   = 1'b0;
        if (state_q == ADDR) begin
            ARVALID_S = gnt ? ARVALID_M1 : ARVALID_M0;
            if (gnt) ARREADY_M1 = ARREADY_S;
            else     ARREADY_M0 = ARREADY_S;
        end else if (state_q == DATA) begin
            RREADY_S = gnt ? RREADY_M1 : RREADY_M0;
            if (gnt) RVALID_M1 = RVALID_S;
            else     RVALID_M0 = RVALID_S;
        end
    end

    // Arbitration FSM with beat counting and sticky length-error detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            gnt        <= 1'b0;
            ptr        <= 1'b0;
            cnt        <= 4'd0;
            len_q      <= 4'd0;
            prot_err_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ARVALID_M0 || ARVALID_M1) begin
                        // Contention resolved by the pointer alone
                        gnt     <= (ARVALID_M0 && ARVALID_M1) ? ptr : ARVALID_M1;
                        state_q <= ADDR;
                    end
                end
                ADDR: begin
                    if (w_ar_hs) begin
                        len_q   <= ARLEN_S;
                        cnt     <= 4'd0;
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_r_hs) begin
                        cnt <= cnt + 4'd1;
                        // RLAST must coincide exactly with the final beat
                        if (RLAST_S != (cnt == len_q)) begin
                            prot_err_q <= 1'b1;
                        end
                        if (RLAST_S) begin
                            state_q <= IDLE;
                            ptr     <= ~gnt;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_axi_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_axi_read_arbiter
// Brief    : Directed self-checking bench for axi_read_arbiter. Inputs are
//            driven on the falling edge, outputs checked before the next
//            rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_axi_read_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  ARID_M0, ARID_M1, ARLEN_M0, ARLEN_M1;
    logic [31:0] ARADDR_M0, ARADDR_M1;
    logic [2:0]  ARSIZE_M0, ARSIZE_M1;
    logic [1:0]  ARBURST_M0, ARBURST_M1;
    logic        ARVALID_M0, ARVALID_M1, ARREADY_M0, ARREADY_M1;
    logic [3:0]  RID_M0, RID_M1;
    logic [31:0] RDATA_M0, RDATA_M1;
    logic [1:0]  RRESP_M0, RRESP_M1;
    logic        RLAST_M0, RLAST_M1, RVALID_M0, RVALID_M1, RREADY_M0, RREADY_M1;
    logic [7:0]  ARID_S;
    logic [31:0] ARADDR_S;
    logic [3:0]  ARLEN_S;
    logic [2:0]  ARSIZE_S;
    logic [1:0]  ARBURST_S;
    logic        ARVALID_S, ARREADY_S;
    logic [7:0]  RID_S;
    logic [31:0] RDATA_S;
    logic [1:0]  RRESP_S;
    logic        RLAST_S, RVALID_S, RREADY_S;
    logic        grant, prot_err;

    int n_checks = 0;
    int n_fail   = 0;

    axi_read_arbiter u_dut (
        .clk(clk), .rst(rst),
        .ARID_M0(ARID_M0), .ARADDR_M0(ARADDR_M0), .ARLEN_M0(ARLEN_M0),
        .ARSIZE_M0(ARSIZE_M0), .ARBURST_M0(ARBURST_M0), .ARVALID_M0(ARVALID_M0),
        .ARREADY_M0(ARREADY_M0), .RID_M0(RID_M0), .RDATA_M0(RDATA_M0),
        .RRESP_M0(RRESP_M0), .RLAST_M0(RLAST_M0), .RVALID_M0(RVALID_M0),
        .RREADY_M0(RREADY_M0),
        .ARID_M1(ARID_M1), .ARADDR_M1(ARADDR_M1), .ARLEN_M1(ARLEN_M1),
        .ARSIZE_M1(ARSIZE_M1), .ARBURST_M1(ARBURST_M1), .ARVALID_M1(ARVALID_M1),
        .ARREADY_M1(ARREADY_M1), .RID_M1(RID_M1), .RDATA_M1(RDATA_M1),
        .RRESP_M1(RRESP_M1), .RLAST_M1(RLAST_M1), .RVALID_M1(RVALID_M1),
        .RREADY_M1(RREADY_M1),
        .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
        .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S), .ARVALID_S(ARVALID_S),
        .ARREADY_S(ARREADY_S), .RID_S(RID_S), .RDATA_S(RDATA_S),
        .RRESP_S(RRESP_S), .RLAST_S(RLAST_S), .RVALID_S(RVALID_S),
        .RREADY_S(RREADY_S),
        .grant(grant), .prot_err(prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        ARID_M0 = '0; ARADDR_M0 = '0; ARLEN_M0 = '0; ARSIZE_M0 = 3'd2; ARBURST_M0 = 2'b01; ARVALID_M0 = 1'b0;
        ARID_M1 = '0; ARADDR_M1 = '0; ARLEN_M1 = '0; ARSIZE_M1 = 3'd2; ARBURST_M1 = 2'b01; ARVALID_M1 = 1'b0;
        RREADY_M0 = 1'b0; RREADY_M1 = 1'b0;
        ARREADY_S = 1'b0; RID_S = '0; RDATA_S = '0; RRESP_S = '0; RLAST_S = 1'b0; RVALID_S = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Issues an AR request and returns at the first falling edge of DATA
    task automatic issue_ar(input logic m, input logic [3:0] id, input logic [3:0] len);
        bit seen;
        seen = 1'b0;
        @(negedge clk);
        if (m) begin ARID_M1 = id; ARADDR_M1 = 32'h1000_0000; ARLEN_M1 = len; ARVALID_M1 = 1'b1; end
        else   begin ARID_M0 = id; ARADDR_M0 = 32'h0000_1000; ARLEN_M0 = len; ARVALID_M0 = 1'b1; end
        ARREADY_S = 1'b1;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (ARVALID_S) seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b1) begin
            n_fail++;
            $display("FAIL ar_timeout: ARVALID_S got %b required 1 within 10 cycles", ARVALID_S);
        end
        @(negedge clk);
        ARVALID_M0 = 1'b0; ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b0;
        ARVALID_M0 = 1'b1; RVALID_S = 1'b1; RREADY_M0 = 1'b1; ARREADY_S = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({ARREADY_M0, ARREADY_M1, ARVALID_S, RVALID_M0, RVALID_M1, RREADY_S} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_handshakes: got %b required 000000",
                     {ARREADY_M0, ARREADY_M1, ARVALID_S, RVALID_M0, RVALID_M1, RREADY_S});
        end
        n_checks++;
        if ({grant, prot_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_status: grant/prot_err got %b required 00", {grant, prot_err});
        end
        clear_inputs();
        rst = 1'b1;
    endtask

    task automatic test_single_m0();
        logic [34:0] exp;
        do_reset();
        @(negedge clk);
        ARID_M0 = 4'h2; ARADDR_M0 = 32'h2000_0000; ARLEN_M0 = 4'd3; ARVALID_M0 = 1'b1;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        #1;
        n_checks++;
        if (ARVALID_S !== 1'b0) begin
            n_fail++; $display("FAIL idle_no_comb_grant: ARVALID_S got %b required 0", ARVALID_S);
        end
        @(negedge clk);
        ARREADY_S = 1'b1;
        #1;
        n_checks++;
        if ({ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARREADY_M0, ARREADY_M1} !== {1'b1, 8'h02, 32'h2000_0000, 4'd3, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL m0_addr_phase: valid=%b id=%h addr=%h len=%0d rdy0=%b rdy1=%b required 1 02 20000000 3 1 0",
                     ARVALID_S, ARID_S, ARADDR_S, ARLEN_S, ARREADY_M0, ARREADY_M1);
        end
        @(negedge clk);
        ARVALID_M0 = 1'b0; ARREADY_S = 1'b0;
        for (int i = 0; i < 4; i++) begin
            RVALID_S = 1'b1; RDATA_S = 32'hA000_0000 + i; RLAST_S = (i == 3); RID_S = 8'h02;
            #1;
            exp = {1'b1, 1'b0, (i == 3), 32'hA000_0000 + i};
            n_checks++;
            if ({RVALID_M0, RVALID_M1, RLAST_M0, RDATA_M0} !== exp) begin
                n_fail++;
                $display("FAIL m0_beat%0d: {v0,v1,last,data} got %h required %h",
                         i, {RVALID_M0, RVALID_M1, RLAST_M0, RDATA_M0}, exp);
            end
            @(negedge clk);
        end
        RLAST_S = 1'b0;
        #1;
        n_checks++;
        if ({RVALID_M0, RREADY_S, ARVALID_S, prot_err} !== 4'b0000) begin
            n_fail++;
            $display("FAIL m0_back_to_idle: {v0,rready_s,arvalid_s,prot_err} got %b required 0000",
                     {RVALID_M0, RREADY_S, ARVALID_S, prot_err});
        end
        RVALID_S = 1'b0;
    endtask

    task automatic test_simultaneous();
        do_reset();
        @(negedge clk);
        ARID_M0 = 4'h1; ARLEN_M0 = 4'd0; ARVALID_M0 = 1'b1;
        ARID_M1 = 4'h5; ARLEN_M1 = 4'd0; ARVALID_M1 = 1'b1;
        RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({grant, ARID_S, ARVALID_S, ARREADY_M1} !== {1'b0, 8'h01, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sim_first_m0: grant=%b id=%h valid=%b rdy1=%b required 0 01 1 0", grant, ARID_S, ARVALID_S, ARREADY_M1);
        end
        @(negedge clk);
        n_checks++;
        if ({grant, ARID_S} !== {1'b0, 8'h01}) begin
            n_fail++;
            $display("FAIL sim_hold_gnt: grant=%b id=%h required 0 01", grant, ARID_S);
        end
        ARREADY_S = 1'b1;
        @(negedge clk);
        ARVALID_M0 = 1'b0; ARREADY_S = 1'b0;
        RVALID_S = 1'b1; RLAST_S = 1'b1; RID_S = 8'h01; RDATA_S = 32'h0000_0011;
        #1;
        n_checks++;
        if ({RVALID_M0, RVALID_M1, ARREADY_M1, RDATA_M1} !== {1'b1, 1'b0, 1'b0, 32'h0000_0011}) begin
            n_fail++;
            $display("FAIL sim_m0_data: v0=%b v1=%b rdy1=%b data1=%h required 1 0 0 00000011", RVALID_M0, RVALID_M1, ARREADY_M1, RDATA_M1);
        end
        @(negedge clk);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        #1;
        n_checks++;
        if (ARVALID_S !== 1'b0) begin
            n_fail++; $display("FAIL sim_idle_gap: ARVALID_S got %b required 0", ARVALID_S);
        end
        @(negedge clk);
        ARREADY_S = 1'b1;
        #1;
        n_checks++;
        if ({grant, ARID_S, ARVALID_S, ARREADY_M1, ARREADY_M0} !== {1'b1, 8'h15, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sim_then_m1: grant=%b id=%h valid=%b rdy1=%b rdy0=%b required 1 15 1 1 0",
                     grant, ARID_S, ARVALID_S, ARREADY_M1, ARREADY_M0);
        end
        @(negedge clk);
        ARVALID_M1 = 1'b0; ARREADY_S = 1'b0;
        RVALID_S = 1'b1; RLAST_S = 1'b1; RID_S = 8'h15;
        #1;
        n_checks++;
        if ({RVALID_M1, RVALID_M0, RID_M1} !== {1'b1, 1'b0, 4'h5}) begin
            n_fail++;
            $display("FAIL sim_m1_data: v1=%b v0=%b rid1=%h required 1 0 5", RVALID_M1, RVALID_M0, RID_M1);
        end
        @(negedge clk);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
    endtask

    task automatic test_back_to_back();
        int k;
        do_reset();
        @(negedge clk);
        ARID_M0 = 4'h3; ARID_M1 = 4'h4; ARLEN_M0 = 4'd0; ARLEN_M1 = 4'd0;
        ARVALID_M0 = 1'b1; ARVALID_M1 = 1'b1; ARREADY_S = 1'b1;
        RVALID_S = 1'b1; RLAST_S = 1'b1; RREADY_M0 = 1'b1; RREADY_M1 = 1'b1;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 4; cyc++) begin
            @(negedge clk);
            if (ARVALID_S) begin
                n_checks++;
                if (grant !== k[0]) begin
                    n_fail++;
                    $display("FAIL b2b_order%0d: grant got %b required %b", k, grant, k[0]);
                end
                k++;
            end
        end
        n_checks++;
        if (k != 4) begin
            n_fail++;
            $display("FAIL b2b_timeout: bursts seen %0d required 4", k);
        end
        repeat (2) @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_prot_err();
        do_reset();
        RREADY_M0 = 1'b1;
        issue_ar(1'b0, 4'h6, 4'd1);
        RVALID_S = 1'b1; RLAST_S = 1'b1; RID_S = 8'h06;
        @(negedge clk);
        RLAST_S = 1'b0;
        #1;
        n_checks++;
        if ({prot_err, RVALID_M0, ARVALID_S} !== 3'b100) begin
            n_fail++;
            $display("FAIL perr_early_last: {prot_err,v0,arvalid_s} got %b required 100", {prot_err, RVALID_M0, ARVALID_S});
        end
        RVALID_S = 1'b0;
        issue_ar(1'b0, 4'h6, 4'd0);
        RVALID_S = 1'b1; RLAST_S = 1'b1;
        @(negedge clk);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        n_checks++;
        if (prot_err !== 1'b1) begin
            n_fail++; $display("FAIL perr_sticky: prot_err got %b required 1", prot_err);
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        n_checks++;
        if (prot_err !== 1'b0) begin
            n_fail++; $display("FAIL perr_reset_clear: prot_err got %b required 0", prot_err);
        end
        RREADY_M0 = 1'b1;
        issue_ar(1'b0, 4'h7, 4'd0);
        RVALID_S = 1'b1; RLAST_S = 1'b0;
        @(negedge clk);
        n_checks++;
        if (prot_err !== 1'b1) begin
            n_fail++; $display("FAIL perr_missing_last: prot_err got %b required 1", prot_err);
        end
        RLAST_S = 1'b1;
        @(negedge clk);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        RREADY_M1 = 1'b1;
        issue_ar(1'b1, 4'h9, 4'd7);
        RVALID_S = 1'b1; RLAST_S = 1'b0; RID_S = 8'h19;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({grant, RVALID_M1} !== 2'b11) begin
            n_fail++; $display("FAIL midrst_pre: {grant,v1} got %b required 11", {grant, RVALID_M1});
        end
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({RVALID_M0, RVALID_M1, RREADY_S, ARVALID_S, grant} !== 5'b00000) begin
            n_fail++;
            $display("FAIL midrst_post: {v0,v1,rready_s,arvalid_s,grant} got %b required 00000",
                     {RVALID_M0, RVALID_M1, RREADY_S, ARVALID_S, grant});
        end
        RVALID_S = 1'b0;
    endtask

    task automatic test_stall();
        do_reset();
        RREADY_M1 = 1'b0;
        issue_ar(1'b1, 4'hA, 4'd1);
        RVALID_S = 1'b1; RDATA_S = 32'hCAFE_0001; RLAST_S = 1'b0; RID_S = 8'h1A;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if ({RREADY_S, RVALID_M1, RDATA_M1} !== {1'b0, 1'b1, 32'hCAFE_0001}) begin
                n_fail++;
                $display("FAIL stall%0d: rready_s=%b v1=%b data1=%h required 0 1 cafe0001", i, RREADY_S, RVALID_M1, RDATA_M1);
            end
            @(negedge clk);
        end
        RREADY_M1 = 1'b1;
        #1;
        n_checks++;
        if (RREADY_S !== 1'b1) begin
            n_fail++; $display("FAIL stall_release: RREADY_S got %b required 1", RREADY_S);
        end
        @(negedge clk);
        RDATA_S = 32'hCAFE_0002; RLAST_S = 1'b1;
        @(negedge clk);
        RVALID_S = 1'b0; RLAST_S = 1'b0;
        #1;
        n_checks++;
        if ({prot_err, ARVALID_S, RVALID_M1} !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_cnt_hold: {prot_err,arvalid_s,v1} got %b required 000", {prot_err, ARVALID_S, RVALID_M1});
        end
    endtask

    initial begin
        test_reset();
        test_single_m0();
        test_simultaneous();
        test_back_to_back();
        test_prot_err();
        test_reset_mid_burst();
        test_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
